// File: rtl/seven_seg_scan_ctrl.sv
// Multi-digit 7-segment scan controller: one-hot digit strobing with blanking gaps,
// value handshake into a pending register that is promoted to the display at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 2,
    parameter int DWELL_CYCLES   = 12000,
    parameter int BLANK_CYCLES   = 120,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);

    // state    | meaning
    // ST_OFF   | enable low, display dark, counters parked at 0
    // ST_BLANK | all digits off for BLANK_CYCLES ahead of digit idx
    // ST_SHOW  | digit idx lit for DWELL_CYCLES

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tick_d;
    logic [VW-1:0]         display_q, display_d;
    logic [VW-1:0]         pending_q;
    logic                  pending_flag_q;
    logic                  swap;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] dig_d;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  upper_zero;
    logic [3:0]            nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    assign value_ready = !pending_flag_q;
    // frame_tick marks the boundary cycle itself, so it doubles as the promote strobe
    assign swap        = frame_tick && pending_flag_q;
    assign display_d   = swap ? pending_q : display_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            idx_q          <= '0;
            display_q      <= '0;
            pending_q      <= '0;
            pending_flag_q <= 1'b0;
            seg_out        <= SEG_OFF;
            dig_sel        <= '0;
            frame_tick     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            display_q  <= display_d;
            seg_out    <= seg_d;
            dig_sel    <= dig_d;
            frame_tick <= tick_d;
            if (swap) begin
                pending_flag_q <= 1'b0;
            end else if (value_valid && value_ready) begin
                pending_q      <= value_in;
                pending_flag_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tick_d  = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    // Outputs are computed from next-cycle state so the registered copies line up with the state
    always_comb begin
        suppress   = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero  = upper_zero && (display_d[4*i +: 4] == 4'h0);
            suppress[i] = blank_lz && upper_zero;
        end
        nibble = display_d[4*int'(idx_d) +: 4];
        seg_d  = SEG_OFF;
        dig_d  = '0;
        if (state_d == ST_SHOW && !suppress[idx_d]) begin
            dig_d = NUM_DIGITS'(1) << idx_d;
            seg_d = ACTIVE_LOW_SEG ? ~hex_to_seg(nibble) : hex_to_seg(nibble);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a short scan (2 digits, dwell 8, blank 2, active-low).
module tb_seven_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] value_in = 8'h00;
    logic       value_valid = 1'b0;
    logic       value_ready;
    logic       blank_lz = 1'b0;
    logic [6:0] seg_out;
    logic [1:0] dig_sel;
    logic       frame_tick;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(2),
        .DWELL_CYCLES(8),
        .BLANK_CYCLES(2),
        .ACTIVE_LOW_SEG(1'b1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .value_in(value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .blank_lz(blank_lz),
        .seg_out(seg_out),
        .dig_sel(dig_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        value_valid = 1'b0;
        value_in    = 8'h00;
        enable      = 1'b1;
        blank_lz    = 1'b0;
        step();
        step();
        resetn = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        int         phase;
        int         frame;
        logic [1:0] e_dig;
        logic [6:0] e_seg;
        logic       e_tick;
        logic       e_rdy;

        // scan timing, load, backpressure
        do_reset();
        for (int c = 0; c < 60; c++) begin
            phase  = c % 20;
            frame  = c / 20;
            e_dig  = (phase >= 2 && phase <= 9) ? 2'b01 : (phase >= 12) ? 2'b10 : 2'b00;
            e_tick = (c > 0) && (phase == 0);
            e_rdy  = !((c >= 6 && c <= 20) || (c >= 22 && c <= 40));
            if (e_dig == 2'b00)      e_seg = 7'h7F;
            else if (frame == 0)     e_seg = 7'h40;
            else if (frame == 1)     e_seg = (e_dig == 2'b01) ? 7'h08 : 7'h30;
            else                     e_seg = 7'h78;
            chk("scan_dig", {6'b0, dig_sel}, {6'b0, e_dig});
            chk("scan_seg", {1'b0, seg_out}, {1'b0, e_seg});
            chk("scan_tick", {7'b0, frame_tick}, {7'b0, e_tick});
            chk("scan_ready", {7'b0, value_ready}, {7'b0, e_rdy});
            if (c == 5)  begin value_valid = 1'b1; value_in = 8'h3A; end
            if (c == 6)  value_valid = 1'b0;
            if (c == 7)  begin value_valid = 1'b1; value_in = 8'h77; end
            if (c == 22) value_valid = 1'b0;
            step();
        end

        // leading-zero suppression
        do_reset();
        blank_lz = 1'b1; value_valid = 1'b1; value_in = 8'h05;
        step();
        value_valid = 1'b0;
        go_to(21);
        chk("lz_ready21", {7'b0, value_ready}, 8'h01);
        value_valid = 1'b1; value_in = 8'h00;
        step();
        value_valid = 1'b0;
        go_to(25);
        chk("lz05_d0_dig", {6'b0, dig_sel}, 8'h01);
        chk("lz05_d0_seg", {1'b0, seg_out}, 8'h12);
        go_to(35);
        chk("lz05_d1_dig", {6'b0, dig_sel}, 8'h00);
        chk("lz05_d1_seg", {1'b0, seg_out}, 8'h7F);
        go_to(41);
        chk("lz_ready41", {7'b0, value_ready}, 8'h01);
        value_valid = 1'b1; value_in = 8'h05;
        step();
        value_valid = 1'b0;
        go_to(45);
        chk("lz00_d0_dig", {6'b0, dig_sel}, 8'h01);
        chk("lz00_d0_seg", {1'b0, seg_out}, 8'h40);
        go_to(55);
        chk("lz00_d1_dig", {6'b0, dig_sel}, 8'h00);
        chk("lz00_d1_seg", {1'b0, seg_out}, 8'h7F);
        go_to(60);
        blank_lz = 1'b0;
        go_to(65);
        chk("nolz_d0_seg", {1'b0, seg_out}, 8'h12);
        go_to(75);
        chk("nolz_d1_dig", {6'b0, dig_sel}, 8'h02);
        chk("nolz_d1_seg", {1'b0, seg_out}, 8'h40);

        // enable drop and re-enable
        do_reset();
        go_to(4);
        chk("en_lit4", {6'b0, dig_sel}, 8'h01);
        enable = 1'b0;
        step();
        chk("en_off_dig", {6'b0, dig_sel}, 8'h00);
        chk("en_off_seg", {1'b0, seg_out}, 8'h7F);
        go_to(10);
        value_valid = 1'b1; value_in = 8'h12;
        step();
        chk("en_off_ready", {7'b0, value_ready}, 8'h00);
        value_valid = 1'b0;
        go_to(29);
        chk("en_off_dig29", {6'b0, dig_sel}, 8'h00);
        chk("en_off_tick29", {7'b0, frame_tick}, 8'h00);
        go_to(30);
        enable = 1'b1;
        step();
        chk("en_tick31", {7'b0, frame_tick}, 8'h01);
        chk("en_dig31", {6'b0, dig_sel}, 8'h00);
        step();
        chk("en_tick32", {7'b0, frame_tick}, 8'h00);
        chk("en_ready32", {7'b0, value_ready}, 8'h01);
        go_to(33);
        chk("en_dig33", {6'b0, dig_sel}, 8'h01);
        chk("en_seg33", {1'b0, seg_out}, 8'h24);
        go_to(40);
        chk("en_dig40", {6'b0, dig_sel}, 8'h01);
        step();
        chk("en_dig41", {6'b0, dig_sel}, 8'h00);

        // reset in the middle of operation with a value pending
        do_reset();
        value_valid = 1'b1; value_in = 8'hC4;
        step();
        value_valid = 1'b0;
        go_to(15);
        chk("rst_pending", {7'b0, value_ready}, 8'h00);
        resetn = 1'b0;
        step();
        chk("rst_ready", {7'b0, value_ready}, 8'h01);
        chk("rst_dig", {6'b0, dig_sel}, 8'h00);
        chk("rst_seg", {1'b0, seg_out}, 8'h7F);
        chk("rst_tick", {7'b0, frame_tick}, 8'h00);
        resetn = 1'b1;
        cyc    = 0;
        for (int c = 0; c <= 20; c++) begin
            phase  = c % 20;
            e_dig  = (phase >= 2 && phase <= 9) ? 2'b01 : (phase >= 12) ? 2'b10 : 2'b00;
            e_seg  = (e_dig == 2'b00) ? 7'h7F : 7'h40;
            e_tick = (c == 20);
            chk("rst_scan_dig", {6'b0, dig_sel}, {6'b0, e_dig});
            chk("rst_scan_seg", {1'b0, seg_out}, {1'b0, e_seg});
            chk("rst_scan_tick", {7'b0, frame_tick}, {7'b0, e_tick});
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
